// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use and MDU scoreboard stalls,
// branch flushes, and saturating stall/flush counters.
module hazard_scoreboard_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int MDU_LAT    = 4,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  PCSrcE,
   input  logic                  RegWriteE,
   input  logic                  RegWriteM,
   input  logic                  RegWriteW,
   input  logic                  ResultSrcE,
   input  logic                  MduStartE,
   input  logic                  Rs1UsedD,
   input  logic                  Rs2UsedD,
   input  logic                  RegWriteD,
   input  logic [REG_ADDR_W-1:0] Rs1_D,
   input  logic [REG_ADDR_W-1:0] Rs2_D,
   input  logic [REG_ADDR_W-1:0] Rd_D,
   input  logic [REG_ADDR_W-1:0] Rs1_E,
   input  logic [REG_ADDR_W-1:0] Rs2_E,
   input  logic [REG_ADDR_W-1:0] RD_E,
   input  logic [REG_ADDR_W-1:0] RD_M,
   input  logic [REG_ADDR_W-1:0] RD_W,
   output logic [1:0]            ForwardAE,
   output logic [1:0]            ForwardBE,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  MduWbValid,
   output logic [REG_ADDR_W-1:0] MduWbRd,
   output logic [CNT_W-1:0]      StallCount,
   output logic [CNT_W-1:0]      FlushCount
);

   localparam int NUM_REGS = 2 ** REG_ADDR_W;

   // MduWbValid is a one-cycle strobe with no back-pressure: the dedicated
   // register-file port always accepts it, so there is no ready signal.
   logic [MDU_LAT-1:0]    mdu_v;
   logic [REG_ADDR_W-1:0] mdu_rd [MDU_LAT];
   logic [NUM_REGS-1:0]   pending;

   logic       mdu_issue;
   logic       load_stall;
   logic       mdu_stall;
   logic       haz_stall;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
      if (RegWriteM && (RD_M != '0) && (RD_M == rs))
         return 2'b10;
      else if (RegWriteW && (RD_W != '0) && (RD_W == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   // A branch in E does not cancel the MDU issue: the E instruction is older.
   assign mdu_issue = MduStartE && (RD_E != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         mdu_v <= '0;
         for (int i = 0; i < MDU_LAT; i++)
            mdu_rd[i] <= '0;
      end else begin
         mdu_v     <= {mdu_v[MDU_LAT-2:0], mdu_issue};
         mdu_rd[0] <= RD_E;
         for (int i = 1; i < MDU_LAT; i++)
            mdu_rd[i] <= mdu_rd[i-1];
      end
   end

   // Every in-flight entry marks its destination, so two ops to one rd keep it
   // pending until the younger one drains.
   always_comb begin
      pending = '0;
      for (int i = 0; i < MDU_LAT; i++)
         if (mdu_v[i])
            pending[mdu_rd[i]] = 1'b1;
      pending[0] = 1'b0;
   end

   always_comb begin
      fwd_a      = fwd_sel(Rs1_E);
      fwd_b      = fwd_sel(Rs2_E);
      load_stall = ResultSrcE && RegWriteE && (RD_E != '0) &&
                   ((Rs1UsedD && (RD_E == Rs1_D)) || (Rs2UsedD && (RD_E == Rs2_D)));
      mdu_stall  = (Rs1UsedD && pending[Rs1_D]) ||
                   (Rs2UsedD && pending[Rs2_D]) ||
                   (RegWriteD && pending[Rd_D]);
      haz_stall  = load_stall || mdu_stall;
   end

   always_comb begin
      ForwardAE  = 2'b00;
      ForwardBE  = 2'b00;
      StallF     = 1'b0;
      StallD     = 1'b0;
      FlushD     = 1'b0;
      FlushE     = 1'b0;
      MduWbValid = 1'b0;
      MduWbRd    = '0;
      if (!rst) begin
         ForwardAE  = fwd_a;
         ForwardBE  = fwd_b;
         // The D instruction is wrong-path under a taken branch, so flush beats stall.
         StallF     = haz_stall && !PCSrcE;
         StallD     = haz_stall && !PCSrcE;
         FlushD     = PCSrcE;
         FlushE     = PCSrcE || haz_stall;
         MduWbValid = mdu_v[MDU_LAT-1];
         MduWbRd    = mdu_rd[MDU_LAT-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (StallD && (StallCount != '1))
            StallCount <= StallCount + 1'b1;
         if (PCSrcE && (FlushCount != '1))
            FlushCount <= FlushCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: stimulus pushes expected output vectors,
// a negedge monitor pops and compares them against the DUT every cycle.
module tb_hazard_scoreboard_unit;

   localparam int W = 82;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       PCSrcE, RegWriteE, RegWriteM, RegWriteW, ResultSrcE, MduStartE;
   logic       Rs1UsedD, Rs2UsedD, RegWriteD;
   logic [4:0] Rs1_D, Rs2_D, Rd_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, FlushD, FlushE, MduWbValid;
   logic [4:0] MduWbRd;
   logic [31:0] StallCount, FlushCount;

   logic [1:0] s_fa, s_fb;
   logic       s_sf, s_sd, s_fd, s_fe, s_wv;
   logic [4:0] s_wrd;
   logic [1:0] sat_sc, sat_fc;

   hazard_scoreboard_unit #(.REG_ADDR_W(5), .MDU_LAT(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .MduStartE(MduStartE),
      .Rs1UsedD(Rs1UsedD), .Rs2UsedD(Rs2UsedD), .RegWriteD(RegWriteD),
      .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
      .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
      .FlushD(FlushD), .FlushE(FlushE), .MduWbValid(MduWbValid), .MduWbRd(MduWbRd),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   // Narrow-counter twin to observe saturation without running billions of cycles.
   hazard_scoreboard_unit #(.REG_ADDR_W(5), .MDU_LAT(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .MduStartE(MduStartE),
      .Rs1UsedD(Rs1UsedD), .Rs2UsedD(Rs2UsedD), .RegWriteD(RegWriteD),
      .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
      .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
      .ForwardAE(s_fa), .ForwardBE(s_fb), .StallF(s_sf), .StallD(s_sd),
      .FlushD(s_fd), .FlushE(s_fe), .MduWbValid(s_wv), .MduWbRd(s_wrd),
      .StallCount(sat_sc), .FlushCount(sat_fc)
   );

   logic [W-1:0] obs;
   assign obs = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, MduWbValid, MduWbRd,
                 StallCount, FlushCount, sat_sc, sat_fc};

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_v;
   string        exp_name;

   function automatic logic [1:0] sat2(input logic [31:0] v);
      return (v > 32'd3) ? 2'd3 : v[1:0];
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_v    = exp_q.pop_front();
         exp_name = name_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b wv=%b wrd=%0d sc=%0d fc=%0d ssc=%0d sfc=%0d, expected %h (got %h)",
                     exp_name, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, MduWbValid,
                     MduWbRd, StallCount, FlushCount, sat_sc, sat_fc, exp_v, obs);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      PCSrcE = 0; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; MduStartE = 0;
      Rs1UsedD = 0; Rs2UsedD = 0; RegWriteD = 0;
      Rs1_D = 0; Rs2_D = 0; Rd_D = 0; Rs1_E = 0; Rs2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
   endtask

   // Push the expected outputs for the current cycle's inputs, then advance one cycle.
   task automatic step(input string name, input logic [1:0] fa, input logic [1:0] fb,
                       input logic st, input logic fd, input logic fe, input logic wv,
                       input logic [4:0] wrd, input logic [31:0] sc, input logic [31:0] fc);
      exp_q.push_back({fa, fb, st, st, fd, fe, wv, wrd, sc, fc, sat2(sc), sat2(fc)});
      name_q.push_back(name);
      tick();
   endtask

   task automatic load_use();
      ResultSrcE = 1; RegWriteE = 1; RD_E = 5'd3; Rs2_D = 5'd3; Rs2UsedD = 1;
   endtask

   task automatic issue(input logic [4:0] rd);
      MduStartE = 1; RD_E = rd;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1;
      clear_in();
      tick();
      tick();

      // Reset gating: every hazard condition active, outputs must stay 0.
      RegWriteM = 1; RD_M = 5'd5; Rs1_E = 5'd5; PCSrcE = 1; load_use(); MduStartE = 1;
      step("rst_gate",      2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 0, 0);
      rst = 0; clear_in();
      step("post_reset",    2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 0, 0);

      // Forwarding priority.
      RegWriteM = 1; RegWriteW = 1; RD_M = 5'd7; RD_W = 5'd7; Rs1_E = 5'd7;
      step("fwd_a_m_wins",  2'b10, 2'b00, 0, 0, 0, 0, 5'd0, 0, 0);
      RD_M = 5'd0;
      step("fwd_a_w_x0m",   2'b01, 2'b00, 0, 0, 0, 0, 5'd0, 0, 0);
      Rs1_E = 5'd0; Rs2_E = 5'd7; RD_M = 5'd7;
      step("fwd_b_m_wins",  2'b00, 2'b10, 0, 0, 0, 0, 5'd0, 0, 0);
      RD_M = 5'd0;
      step("fwd_b_w",       2'b00, 2'b01, 0, 0, 0, 0, 5'd0, 0, 0);
      RegWriteM = 0; RegWriteW = 0; RD_M = 5'd7;
      step("fwd_b_no_we",   2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 0, 0);

      // Load-use.
      clear_in(); load_use();
      step("load_use",      2'b00, 2'b00, 1, 0, 1, 0, 5'd0, 0, 0);
      Rs2UsedD = 0;
      step("load_unused",   2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 1, 0);
      Rs2UsedD = 1; RD_E = 5'd0;
      step("load_rd_x0",    2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 1, 0);

      // Branch beats stall.
      load_use(); PCSrcE = 1;
      step("branch_over",   2'b00, 2'b00, 0, 1, 1, 0, 5'd0, 1, 0);
      clear_in();
      repeat (4) tick();
      step("branch_counts", 2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 1, 1);

      // MDU latency: issue x9, D keeps reading x9.
      issue(5'd9); Rs1_D = 5'd9; Rs1UsedD = 1;
      step("mdu_t0",        2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 1, 1);
      MduStartE = 0; RD_E = 5'd0;
      step("mdu_t1",        2'b00, 2'b00, 1, 0, 1, 0, 5'd0, 1, 1);
      step("mdu_t2",        2'b00, 2'b00, 1, 0, 1, 0, 5'd0, 2, 1);
      step("mdu_t3",        2'b00, 2'b00, 1, 0, 1, 0, 5'd0, 3, 1);
      step("mdu_t4_wb",     2'b00, 2'b00, 1, 0, 1, 1, 5'd9, 4, 1);
      step("mdu_t5_clear",  2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 5, 1);

      // WAW on a pending rd; an x0 issue never becomes valid or pending.
      clear_in(); issue(5'd10);
      step("waw_issue",     2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 5, 1);
      issue(5'd0); RegWriteD = 1; Rd_D = 5'd10;
      step("waw_stall",     2'b00, 2'b00, 1, 0, 1, 0, 5'd0, 5, 1);
      clear_in(); Rs1_D = 5'd0; Rs1UsedD = 1;
      step("x0_not_pend",   2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 6, 1);
      clear_in();
      step("waw_w3",        2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 6, 1);
      step("waw_wb",        2'b00, 2'b00, 0, 0, 0, 1, 5'd10, 6, 1);
      step("x0_no_wb",      2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 6, 1);

      // Back-to-back issues.
      issue(5'd4);
      step("b2b_i4",        2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 6, 1);
      issue(5'd5);
      step("b2b_i5",        2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 6, 1);
      clear_in();
      step("b2b_c2",        2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 6, 1);
      step("b2b_c3",        2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 6, 1);
      step("b2b_wb4",       2'b00, 2'b00, 0, 0, 0, 1, 5'd4, 6, 1);
      step("b2b_wb5",       2'b00, 2'b00, 0, 0, 0, 1, 5'd5, 6, 1);
      step("b2b_done",      2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 6, 1);

      // Two in-flight ops to x6: pending until the younger retires.
      issue(5'd6);
      step("same_i0",       2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 6, 1);
      issue(5'd6);
      step("same_i1",       2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 6, 1);
      clear_in();
      step("same_c2",       2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 6, 1);
      step("same_c3",       2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 6, 1);
      step("same_old_wb",   2'b00, 2'b00, 0, 0, 0, 1, 5'd6, 6, 1);
      Rs1_D = 5'd6; Rs1UsedD = 1;
      step("same_still",    2'b00, 2'b00, 1, 0, 1, 1, 5'd6, 6, 1);
      step("same_free",     2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 7, 1);

      // Reset mid-flight drops both ops and the counters.
      clear_in(); issue(5'd4);
      step("rst_i4",        2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 7, 1);
      issue(5'd5);
      step("rst_i5",        2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 7, 1);
      clear_in(); rst = 1;
      step("rst_mid",       2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 7, 1);
      rst = 0; Rs1_D = 5'd4; Rs1UsedD = 1;
      step("rst_x4_free",   2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 0, 0);
      Rs1_D = 5'd5;
      step("rst_x5_free",   2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 0, 0);
      clear_in();
      step("rst_no_wb_a",   2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 0, 0);
      step("rst_no_wb_b",   2'b00, 2'b00, 0, 0, 0, 0, 5'd0, 0, 0);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Next-generation hazard unit for the 5-stage RISC-V pipeline.
- Adds a register-pending scoreboard for a pipelined multi-cycle multiply/divide unit (MDU) with parametrised latency.
- Adds operand-use qualification to suppress false load-use stalls, and branch-over-stall priority.
- Adds saturating stall/flush performance counters. Sits beside the datapath and drives forwarding muxes plus F/D/E stall and flush controls.

Parameters:
REG_ADDR_W, 5, register address width; NUM_REGS = 2**REG_ADDR_W
MDU_LAT, 4, MDU latency in cycles from issue in E to writeback (>=2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
PCSrcE  in  1  taken branch/jump resolved in E
RegWriteE, RegWriteM, RegWriteW  in  1  each  register-write enables per stage
ResultSrcE  in  1  E-stage instruction is a load
MduStartE  in  1  E-stage instruction issues to MDU this cycle
Rs1UsedD, Rs2UsedD  in  1  each  D instruction actually reads Rs1/Rs2
RegWriteD  in  1  D instruction writes Rd_D
Rs1_D, Rs2_D, Rd_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W  in  REG_ADDR_W each
ForwardAE, ForwardBE  out  2  00 reg file, 10 from M, 01 from W
StallF, StallD, FlushD, FlushE  out  1 each
MduWbValid  out  1  MDU result writes back this cycle (dedicated RF port)
MduWbRd  out  REG_ADDR_W  MDU writeback destination
StallCount, FlushCount  out  CNT_W each

Behaviour:
- Reset: rst=1 at a clk edge clears the MDU tracking shift register and both counters.
- While rst=1, all combinational outputs are forced to 0: Forward*=00, stalls/flushes=0, MduWbValid=0, MduWbRd=0.
- Forwarding, per operand:
  - 10 if RegWriteM, RD_M!=0, RD_M==Rs*_E.
  - Else 01 if RegWriteW, RD_W!=0, RD_W==Rs*_E.
  - Else 00. M beats W.
- loadStall = ResultSrcE & RegWriteE & RD_E!=0 & ((Rs1UsedD & RD_E==Rs1_D) | (Rs2UsedD & RD_E==Rs2_D)).
- MDU tracking:
  - MDU_LAT-entry shift register of {valid, rd}, advancing every cycle.
  - Entry 0 loads {MduStartE & RD_E!=0, RD_E}. Issue is accepted regardless of PCSrcE, because the E instruction is older than the branch target.
  - The last entry drives MduWbValid/MduWbRd. For an issue in cycle t, MduWbValid=1 in cycle t+MDU_LAT.
  - Pipelined: one issue per cycle is accepted with no structural stall.
- Pending[r] = OR over all valid entries with rd==r. A register is pending in cycles t+1..t+MDU_LAT and is clear at t+MDU_LAT+1.
- mduStall = (Rs1UsedD & Pending[Rs1_D]) | (Rs2UsedD & Pending[Rs2_D]) | (RegWriteD & Pending[Rd_D]). The last term blocks WAW. x0 is never pending.
- hazStall = loadStall | mduStall.
- Output priority:
  - StallF = StallD = hazStall & ~PCSrcE. A flush wins because the D instruction is wrong-path.
  - FlushD = PCSrcE.
  - FlushE = PCSrcE | hazStall.
- Counters:
  - StallCount increments each cycle StallD=1.
  - FlushCount increments each cycle PCSrcE=1.
  - Both saturate at all-ones and do not wrap.
- Two in-flight MDU ops to the same rd: Pending stays set until the younger one retires.

Test Plan:
- Reset gating: rst=1, RegWriteM=1, RD_M=5, Rs1_E=5 -> ForwardAE=00. Then rst=1 for one edge -> StallCount=FlushCount=0 and MduWbValid=0.
- Forward priority: RegWriteM=RegWriteW=1, RD_M=RD_W=7=Rs1_E -> ForwardAE=10. Set RD_M=0 -> ForwardAE=01. Set Rs2_E=7 -> ForwardBE follows the same rules.
- Load-use: ResultSrcE=RegWriteE=1, RD_E=3, Rs2_D=3, Rs2UsedD=1 -> StallF=StallD=FlushE=1 and StallCount+1. With Rs2UsedD=0, or with RD_E=0 -> all 0.
- MDU latency (MDU_LAT=4): MduStartE, RD_E=9 at cycle 0; D holds Rs1_D=9, Rs1UsedD=1 -> StallD=1 in cycles 1-4; MduWbValid=1, MduWbRd=9 in cycle 4; StallD=0 in cycle 5; StallCount=4.
- Branch over stall: load-use condition together with PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0, FlushCount+1, StallCount unchanged.
- Back-to-back and reset: issue rd=4 then rd=5 in consecutive cycles -> MduWbValid in cycles 4 and 5 with rd 4 then 5. Repeat, asserting rst in cycle 2 -> Pending cleared, no MduWbValid afterwards, and a D read of x4 does not stall.
